harmonic_note_detector: RTL and testbench

HARMONIC_NOTE_DETECTOR -- requirements
Module: harmonic_note_detector

---
 rtl/harmonic_note_detector_if.sv | 45 ++++
 rtl/harmonic_note_detector.sv | 172 +++++++++++++++++
 tb/tb_harmonic_note_detector.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/harmonic_note_detector_if.sv
// Harmonic note detector bus bundle.
// Sample stream, note map writes, controls and note results.
interface harmonic_note_detector_if #(
  parameter int NUM_BINS  = 64,
  parameter int NUM_HARM  = 16,
  parameter int NUM_NOTES = 25,
  parameter int DATA_W    = 32
);
  localparam int ACC_W  = DATA_W + 4;
  localparam int BIN_W  = $clog2(NUM_BINS * NUM_HARM);
  localparam int ADDR_W = $clog2(NUM_BINS);
  localparam int NOTE_W = $clog2(NUM_NOTES) + 1;

  logic                 i_valid;
  logic                 o_ready;
  logic [BIN_W-1:0]     i_bin;
  logic [DATA_W-1:0]    i_mag;
  logic                 i_last;
  logic                 i_map_we;
  logic [ADDR_W-1:0]    i_map_addr;
  logic [NOTE_W-1:0]    i_map_note;
  logic [1:0]           i_map_shift;
  logic [ACC_W-1:0]     i_thresh;
  logic                 i_multi;
  logic [NUM_NOTES-1:0] o_note;
  logic                 o_note_valid;
  logic [ACC_W:0]       o_max_onset;
  logic                 o_overrun;

  modport master (
    output i_valid, i_bin, i_mag, i_last,
    output i_map_we, i_map_addr, i_map_note,
    output i_map_shift, i_thresh, i_multi,
    input  o_ready, o_note, o_note_valid,
    input  o_max_onset, o_overrun
  );

  modport slave (
    input  i_valid, i_bin, i_mag, i_last,
    input  i_map_we, i_map_addr, i_map_note,
    input  i_map_shift, i_thresh, i_multi,
    output o_ready, o_note, o_note_valid,
    output o_max_onset, o_overrun
  );
endinterface

// File: rtl/harmonic_note_detector.sv
// Harmonic-sum spectrum to note onset detector.
// Frames are accumulated, mapped to notes, diffed and thresholded.
module harmonic_note_detector #(
  parameter int NUM_BINS  = 64,
  parameter int NUM_HARM  = 16,
  parameter int NUM_NOTES = 25,
  parameter int DATA_W    = 32
) (
  input logic i_clk,
  input logic i_rst,
  harmonic_note_detector_if.slave bus
);
  localparam int ACC_W  = DATA_W + 4;
  localparam int ADDR_W = $clog2(NUM_BINS);
  localparam int NOTE_W = $clog2(NUM_NOTES) + 1;
  localparam int NIDX_W = $clog2(NUM_NOTES);
  localparam int CNT_W  =
    $clog2(NUM_BINS > NUM_NOTES ? NUM_BINS : NUM_NOTES);

  typedef enum logic [2:0] {
    ACCUM, MAP, DIFF, MAX, DECIDE
  } state_t;

  typedef logic [ACC_W-1:0]       acc_t;
  typedef logic signed [ACC_W:0]  ons_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  acc_t               hsum     [NUM_BINS];
  acc_t               now_mag  [NUM_NOTES];
  acc_t               prev_mag [NUM_NOTES];
  ons_t               onset    [NUM_NOTES];
  logic [NOTE_W-1:0]  map_note [NUM_BINS];
  logic [1:0]         map_shift[NUM_BINS];
  ons_t               max_val;
  logic [NIDX_W-1:0]  max_idx;

  acc_t               add [NUM_BINS];
  logic               take;
  logic               last_cnt;
  logic [ADDR_W-1:0]  b_idx;
  logic [NIDX_W-1:0]  n_idx;
  logic               map_hit;
  logic [NIDX_W-1:0]  map_n;
  acc_t               map_val;
  ons_t               thresh_s;
  logic [NUM_NOTES-1:0] over;

  function automatic acc_t sat_add(acc_t a, acc_t b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  assign bus.o_ready = (state == ACCUM);
  assign take     = bus.i_valid && bus.o_ready;
  assign b_idx    = cnt[ADDR_W-1:0];
  assign n_idx    = cnt[NIDX_W-1:0];
  assign map_hit  = map_note[b_idx] < NOTE_W'(NUM_NOTES);
  assign map_n    = map_note[b_idx][NIDX_W-1:0];
  assign map_val  = hsum[b_idx] >> map_shift[b_idx];
  assign thresh_s = $signed({1'b0, bus.i_thresh});
  assign last_cnt = (state == MAP) ?
    (cnt == CNT_W'(NUM_BINS - 1)) :
    (cnt == CNT_W'(NUM_NOTES - 1));

  // Per base bin: one i_mag for each harmonic h with b*h == i_bin
  always_comb begin
    for (int b = 0; b < NUM_BINS; b++) begin
      add[b] = '0;
      for (int h = 1; h <= NUM_HARM; h++)
        if (int'(bus.i_bin) == b * h)
          add[b] = sat_add(add[b], acc_t'(bus.i_mag));
    end
  end

  // Multi-note decision: every onset strictly above threshold
  always_comb begin
    over = '0;
    for (int n = 0; n < NUM_NOTES; n++)
      over[n] = onset[n] > thresh_s;
  end

  // Frame FSM: accumulate, map, diff, max search, decide
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ACCUM;
      cnt     <= '0;
      max_val <= '0;
      max_idx <= '0;
      for (int b = 0; b < NUM_BINS; b++) begin
        hsum[b]      <= '0;
        map_note[b]  <= '1;
        map_shift[b] <= '0;
      end
      for (int n = 0; n < NUM_NOTES; n++) begin
        now_mag[n]  <= '0;
        prev_mag[n] <= '0;
        onset[n]    <= '0;
      end
      bus.o_note       <= '0;
      bus.o_note_valid <= 1'b0;
      bus.o_max_onset  <= '0;
      bus.o_overrun    <= 1'b0;
    end else begin
      bus.o_note_valid <= 1'b0;
      if (bus.i_valid && !bus.o_ready)
        bus.o_overrun <= 1'b1;
      unique case (state)
        ACCUM: begin
          if (bus.i_map_we &&
              int'(bus.i_map_addr) < NUM_BINS) begin
            map_note[bus.i_map_addr]  <= bus.i_map_note;
            map_shift[bus.i_map_addr] <= bus.i_map_shift;
          end
          if (take) begin
            for (int b = 0; b < NUM_BINS; b++)
              hsum[b] <= sat_add(hsum[b], add[b]);
            if (bus.i_last) begin
              state <= MAP;
              cnt   <= '0;
            end
          end
        end
        MAP: begin
          if (map_hit)
            now_mag[map_n] <= sat_add(now_mag[map_n], map_val);
          cnt <= last_cnt ? '0 : cnt + 1'b1;
          if (last_cnt)
            state <= DIFF;
        end
        DIFF: begin
          onset[n_idx] <= $signed({1'b0, now_mag[n_idx]}) -
                          $signed({1'b0, prev_mag[n_idx]});
          prev_mag[n_idx] <= now_mag[n_idx];
          cnt <= last_cnt ? '0 : cnt + 1'b1;
          if (last_cnt) begin
            state   <= MAX;
            max_val <= {1'b1, {ACC_W{1'b0}}};
            max_idx <= '0;
          end
        end
        MAX: begin
          if (onset[n_idx] > max_val) begin
            max_val <= onset[n_idx];
            max_idx <= n_idx;
          end
          cnt <= last_cnt ? '0 : cnt + 1'b1;
          if (last_cnt)
            state <= DECIDE;
        end
        DECIDE: begin
          if (bus.i_multi)
            bus.o_note <= over;
          else if (max_val > thresh_s)
            bus.o_note <= NUM_NOTES'(1) << max_idx;
          else
            bus.o_note <= '0;
          bus.o_max_onset  <= max_val;
          bus.o_note_valid <= 1'b1;
          for (int b = 0; b < NUM_BINS; b++)
            hsum[b] <= '0;
          for (int n = 0; n < NUM_NOTES; n++)
            now_mag[n] <= '0;
          cnt   <= '0;
          state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_harmonic_note_detector.sv
// Scoreboard bench for harmonic_note_detector.
// Frame-level reference model feeds a queue checked by a monitor.
module tb_harmonic_note_detector;
  localparam int NB  = 64;
  localparam int NH  = 16;
  localparam int NN  = 25;
  localparam int DW  = 32;
  localparam int AW  = DW + 4;
  localparam int LAT = NB + 2 * NN + 1;
  localparam longint unsigned MAXACC = (64'd1 << AW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  harmonic_note_detector_if #(
    .NUM_BINS(NB), .NUM_HARM(NH),
    .NUM_NOTES(NN), .DATA_W(DW)
  ) bus ();

  harmonic_note_detector #(
    .NUM_BINS(NB), .NUM_HARM(NH),
    .NUM_NOTES(NN), .DATA_W(DW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_pass = 0;
  int n_tot  = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  longint unsigned m_hsum [NB];
  longint unsigned m_now  [NN];
  longint unsigned m_prev [NN];
  int              m_note [NB];
  int              m_shift[NB];
  bit              m_ovr;

  typedef struct {
    logic [NN-1:0] note;
    longint        maxo;
    longint        t_acc;
  } exp_t;
  exp_t sbq[$];

  function automatic void chk(string name, longint act, longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  function automatic void m_reset();
    for (int b = 0; b < NB; b++) begin
      m_hsum[b]  = 0;
      m_note[b]  = 63;
      m_shift[b] = 0;
    end
    for (int n = 0; n < NN; n++) begin
      m_now[n]  = 0;
      m_prev[n] = 0;
    end
    m_ovr = 0;
  endfunction

  function automatic longint unsigned sat(longint unsigned v);
    return (v > MAXACC) ? MAXACC : v;
  endfunction

  // Harmonic sum: base bin k collects every sample at bin k*h
  function automatic void m_sample(int bin, longint unsigned mag);
    for (int h = 1; h <= NH; h++)
      if (bin % h == 0 && bin / h < NB)
        m_hsum[bin / h] = sat(m_hsum[bin / h] + mag);
  endfunction

  function automatic void m_frame(longint thr, bit multi,
                                  output logic [NN-1:0] note,
                                  output longint mx);
    longint ons[NN];
    longint best;
    int idx;
    for (int b = 0; b < NB; b++)
      if (m_note[b] < NN)
        m_now[m_note[b]] =
          sat(m_now[m_note[b]] + (m_hsum[b] >> m_shift[b]));
    for (int n = 0; n < NN; n++) begin
      ons[n] = longint'(m_now[n]) - longint'(m_prev[n]);
      m_prev[n] = m_now[n];
    end
    best = -(longint'(1) << 62);
    idx = 0;
    for (int n = 0; n < NN; n++)
      if (ons[n] > best) begin
        best = ons[n];
        idx = n;
      end
    note = '0;
    for (int n = 0; n < NN; n++)
      if (multi) note[n] = ons[n] > thr;
      else note[n] = (n == idx) && (best > thr);
    mx = best;
    for (int b = 0; b < NB; b++) m_hsum[b] = 0;
    for (int n = 0; n < NN; n++) m_now[n] = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.o_ready && n < 400) begin
      tick();
      n++;
    end
    if (!bus.o_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic map_wr(int a, int note, int sh);
    wait_ready();
    bus.i_map_we    = 1'b1;
    bus.i_map_addr  = 6'(a);
    bus.i_map_note  = 6'(note);
    bus.i_map_shift = 2'(sh);
    tick();
    bus.i_map_we = 1'b0;
    m_note[a]  = note;
    m_shift[a] = sh;
  endtask

  task automatic send(int bin, longint unsigned mag,
                      bit last, bit keep);
    exp_t e;
    logic [NN-1:0] nt;
    longint mx;
    wait_ready();
    bus.i_valid = 1'b1;
    bus.i_bin   = 10'(bin);
    bus.i_mag   = DW'(mag);
    bus.i_last  = last;
    tick();
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    m_sample(bin, mag);
    if (last && keep) begin
      m_frame(longint'(bus.i_thresh), bus.i_multi, nt, mx);
      e.note  = nt;
      e.maxo  = mx;
      e.t_acc = cyc;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sbq.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    if (sbq.size() != 0) begin
      chk("result_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_reset();
    tick();
  endtask

  task automatic chk_rst_outputs(string tag);
    chk({tag, "_ready"}, bus.o_ready, 1);
    chk({tag, "_note"}, bus.o_note, 0);
    chk({tag, "_valid"}, bus.o_note_valid, 0);
    chk({tag, "_max"}, bus.o_max_onset, 0);
    chk({tag, "_overrun"}, bus.o_overrun, 0);
  endtask

  // Monitor: pops one expectation per o_note_valid pulse
  always @(negedge clk) begin : mon
    exp_t e;
    static bit last_v = 1'b0;
    if (!rst && bus.o_note_valid) begin
      if (last_v) chk("valid_pulse_len", 2, 1);
      if (sbq.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("note", bus.o_note, e.note);
        chk("max_onset",
            longint'($signed(bus.o_max_onset)), e.maxo);
        chk("latency", cyc - e.t_acc, LAT);
        chk("ready_at_valid", bus.o_ready, 1);
      end
    end
    last_v = bus.o_note_valid;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int ns;
    int bin;
    longint unsigned mag;
    bus.i_valid = 0; bus.i_bin = 0; bus.i_mag = 0;
    bus.i_last = 0; bus.i_map_we = 0; bus.i_map_addr = 0;
    bus.i_map_note = 0; bus.i_map_shift = 0;
    bus.i_thresh = 0; bus.i_multi = 0;
    m_reset();
    do_reset();
    chk_rst_outputs("rst0");

    // single note onset, then repeat, then silence
    bus.i_thresh = 100;
    map_wr(4, 3, 0);
    for (int k = 0; k < 2; k++) begin
      send(4, 50, 0, 1);
      send(8, 50, 0, 1);
      send(12, 50, 1, 1);
      wait_idle();
    end
    send(4, 0, 1, 1);
    wait_idle();

    // tie between notes 2 and 5, single then multi
    for (int k = 0; k < 2; k++) begin
      do_reset();
      map_wr(11, 2, 0);
      map_wr(13, 5, 0);
      bus.i_thresh = 100;
      bus.i_multi = k[0];
      send(11, 200, 0, 1);
      send(13, 200, 1, 1);
      wait_idle();
    end

    // saturation on bin 0
    do_reset();
    bus.i_multi = 0;
    map_wr(0, 0, 0);
    for (int i = 0; i < 20; i++)
      send(0, 64'hFFFF_FFFF, i == 19, 1);
    wait_idle();

    // overrun during MAP, map write during DIFF
    do_reset();
    bus.i_thresh = 100;
    map_wr(4, 3, 0);
    send(4, 70, 0, 1);
    send(6, 30, 1, 1);
    repeat (3) tick();
    bus.i_valid = 1'b1;
    bus.i_bin = 10'd4;
    bus.i_mag = 32'd999;
    repeat (10) tick();
    bus.i_valid = 1'b0;
    m_ovr = 1;
    chk("overrun_set", bus.o_overrun, m_ovr);
    repeat (56) tick();
    bus.i_map_we = 1'b1;
    bus.i_map_addr = 6'd4;
    bus.i_map_note = 6'd7;
    bus.i_map_shift = 2'd1;
    tick();
    bus.i_map_we = 1'b0;
    wait_idle();
    bus.i_thresh = 10;
    send(4, 40, 1, 1);
    wait_idle();
    chk("overrun_sticky", bus.o_overrun, m_ovr);

    // reset in the middle of the max search
    map_wr(20, 1, 0);
    bus.i_thresh = 100;
    send(20, 500, 1, 0);
    repeat (95) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_reset();
    chk_rst_outputs("rst_max");
    repeat (40) tick();
    map_wr(20, 1, 0);
    send(20, 500, 1, 1);
    wait_idle();

    // randomized frames
    for (int f = 0; f < 14; f++) begin
      for (int i = 0; i < 6; i++)
        map_wr($urandom_range(0, NB - 1), $urandom_range(0, 31),
               $urandom_range(0, 3));
      bus.i_thresh = ($urandom_range(0, 7) == 0) ?
        AW'($urandom) : AW'($urandom_range(0, 3000));
      bus.i_multi = $urandom_range(0, 1);
      ns = $urandom_range(1, 12);
      for (int s = 0; s < ns; s++) begin
        bin = ($urandom_range(0, 1) == 1) ?
          $urandom_range(0, 127) : $urandom_range(0, 1023);
        mag = ($urandom_range(0, 9) == 0) ?
          64'hFFFF_FFFF : 64'($urandom_range(0, 4095));
        send(bin, mag, s == ns - 1, 1);
      end
      wait_idle();
    end
    chk("overrun_final", bus.o_overrun, m_ovr);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
